// File: rtl/avg_pool_feeder.sv
// Re-streams a 7x7xC HWC feature map channel-major as POOL_SIZE-element bursts, one channel per pooling result.
// Optional busy-cycle counter: define AVG_POOL_FEEDER_CYCLE_CNT_EN.
module avg_pool_feeder #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_BITS  = 16,
    parameter int POOL_SIZE  = 49
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [ADDR_BITS-1:0]  base_addr_i,
    input  logic [ADDR_BITS-1:0]  num_ch_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [ADDR_BITS-1:0]  cur_ch_o,
    output logic                  mem_rd_en_o,
    output logic [ADDR_BITS-1:0]  mem_addr_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  pool_valid_o,
    output logic                  pool_last_o,
    output logic [DATA_WIDTH-1:0] pool_data_o,
    input  logic                  pool_result_valid_i,
    output logic [31:0]           cycle_cnt_o
);

    localparam int PIX_W = $clog2(POOL_SIZE + 1);
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(POOL_SIZE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_RES,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_BITS-1:0] base_q;
    logic [ADDR_BITS-1:0] num_ch_q;
    logic [ADDR_BITS-1:0] ch_q;
    logic [ADDR_BITS-1:0] ptr_q;
    logic [PIX_W-1:0]     pix_q;
    logic                 valid_q;
    logic                 last_q;

    logic rd_en;
    logic busy;
    logic done;
    logic start_acc;
    logic res_acc;
    logic last_ch;

    assign last_ch = (ch_q == num_ch_q - ADDR_BITS'(1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        start_acc = 1'b0;
        res_acc   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_i) begin
                    start_acc = 1'b1;
                    state_nxt = (num_ch_i == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                busy  = 1'b1;
                rd_en = 1'b1;
                if (pix_q == PIX_LAST) begin
                    state_nxt = S_WAIT_RES;
                end
            end
            S_WAIT_RES: begin
                busy = 1'b1;
                if (pool_result_valid_i) begin
                    res_acc   = 1'b1;
                    state_nxt = last_ch ? S_DONE : S_ISSUE;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // ptr walks one pixel (stride C) per read; each new channel restarts at base+ch.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            base_q   <= '0;
            num_ch_q <= '0;
            ch_q     <= '0;
            ptr_q    <= '0;
            pix_q    <= '0;
        end else if (start_acc) begin
            base_q   <= base_addr_i;
            num_ch_q <= num_ch_i;
            ch_q     <= '0;
            ptr_q    <= base_addr_i;
            pix_q    <= '0;
        end else if (rd_en) begin
            ptr_q <= ptr_q + num_ch_q;
            pix_q <= pix_q + PIX_W'(1);
        end else if (res_acc && !last_ch) begin
            ch_q  <= ch_q + ADDR_BITS'(1);
            ptr_q <= base_q + ch_q + ADDR_BITS'(1);
            pix_q <= '0;
        end
    end

    // SRAM returns data one cycle after the strobe, so valid/last are aligned by one register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= rd_en;
            last_q  <= rd_en && (pix_q == PIX_LAST);
        end
    end

    assign busy_o       = busy;
    assign done_o       = done;
    assign cur_ch_o     = ch_q;
    assign mem_rd_en_o  = rd_en;
    assign mem_addr_o   = rd_en ? ptr_q : '0;
    assign pool_valid_o = valid_q;
    assign pool_last_o  = last_q;
    assign pool_data_o  = mem_rdata_i;

`ifdef AVG_POOL_FEEDER_CYCLE_CNT_EN
    logic [31:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (start_acc) begin
            cnt_q <= '0;
        end else if (busy && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign cycle_cnt_o = cnt_q;
`else
    assign cycle_cnt_o = '0;
`endif

endmodule

// File: tb/tb_avg_pool_feeder.sv
// Scoreboard bench for avg_pool_feeder: expected reads/elements queued at start, checked as the DUT emits them.
module tb_avg_pool_feeder;

    localparam int DW = 16;
    localparam int AW = 16;
    localparam int PS = 49;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          start_i;
    logic [AW-1:0] base_addr_i;
    logic [AW-1:0] num_ch_i;
    logic          busy_o;
    logic          done_o;
    logic [AW-1:0] cur_ch_o;
    logic          mem_rd_en_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_rdata_i = '0;
    logic          pool_valid_o;
    logic          pool_last_o;
    logic [DW-1:0] pool_data_o;
    logic          pool_result_valid_i;
    logic [31:0]   cycle_cnt_o;

    avg_pool_feeder #(.DATA_WIDTH(DW), .ADDR_BITS(AW), .POOL_SIZE(PS)) dut (
        .clk_i               (clk_i),
        .rst_ni              (rst_ni),
        .start_i             (start_i),
        .base_addr_i         (base_addr_i),
        .num_ch_i            (num_ch_i),
        .busy_o              (busy_o),
        .done_o              (done_o),
        .cur_ch_o            (cur_ch_o),
        .mem_rd_en_o         (mem_rd_en_o),
        .mem_addr_o          (mem_addr_o),
        .mem_rdata_i         (mem_rdata_i),
        .pool_valid_o        (pool_valid_o),
        .pool_last_o         (pool_last_o),
        .pool_data_o         (pool_data_o),
        .pool_result_valid_i (pool_result_valid_i),
        .cycle_cnt_o         (cycle_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [DW-1:0] dat;
        logic          last;
    } exp_t;

    logic [AW-1:0] exp_addr[$];
    exp_t          exp_dat[$];
    int            n_tests = 0;
    int            n_fail  = 0;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return a ^ 16'h5A3C;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // SRAM model: one-cycle read latency, garbage when not read
    always @(posedge clk_i)
        mem_rdata_i <= mem_rd_en_o ? mem_word(mem_addr_o) : 16'hDEAD;

    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (mem_rd_en_o) begin
                if (exp_addr.size() == 0) check("rd_extra", 32'(mem_rd_en_o), 32'd0);
                else check("rd_addr", 32'(mem_addr_o), 32'(exp_addr.pop_front()));
            end
            if (pool_valid_o) begin
                if (exp_dat.size() == 0) begin
                    check("valid_extra", 32'(pool_valid_o), 32'd0);
                end else begin
                    exp_t e;
                    e = exp_dat.pop_front();
                    check("pool_data", 32'(pool_data_o), 32'(e.dat));
                    check("pool_last", 32'(pool_last_o), 32'(e.last));
                end
            end else if (pool_last_o) begin
                check("last_no_valid", 32'(pool_last_o), 32'd0);
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_exp(input logic [AW-1:0] base, input logic [AW-1:0] c);
        logic [AW-1:0] a;
        exp_t e;
        for (int ch = 0; ch < int'(c); ch++) begin
            for (int p = 0; p < PS; p++) begin
                a = base + AW'(ch) + AW'(p) * c;
                exp_addr.push_back(a);
                e.dat  = mem_word(a);
                e.last = (p == PS - 1);
                exp_dat.push_back(e);
            end
        end
    endtask

    task automatic start_job(input logic [AW-1:0] base, input logic [AW-1:0] c);
        push_exp(base, c);
        base_addr_i = base;
        num_ch_i    = c;
        start_i     = 1'b1;
        step();
        start_i     = 1'b0;
        base_addr_i = 16'h1234;
        num_ch_i    = 16'h0007;
    endtask

    task automatic run_job(input logic [AW-1:0] base, input logic [AW-1:0] c, input int d, input bit spur);
        int k;
        logic [31:0] exp_cnt;
        start_job(base, c);
`ifdef AVG_POOL_FEEDER_CYCLE_CNT_EN
        exp_cnt = 32'(c) * 32'(50 + d);
`else
        exp_cnt = 32'd0;
`endif
        if (c == 0) begin
            check("c0_done", 32'(done_o), 32'd1);
            check("c0_busy", 32'(busy_o), 32'd0);
            check("c0_rd", 32'(mem_rd_en_o), 32'd0);
            step();
            check("c0_done_pulse", 32'(done_o), 32'd0);
            check("c0_busy2", 32'(busy_o), 32'd0);
            check("c0_cnt", cycle_cnt_o, 32'd0);
            return;
        end
        check("busy_rise", 32'(busy_o), 32'd1);
        check("first_rd", 32'(mem_rd_en_o), 32'd1);
        if (spur) begin
            repeat (5) step();
            start_i             = 1'b1;
            base_addr_i         = 16'h4000;
            num_ch_i            = 16'h0001;
            pool_result_valid_i = 1'b1;
            step();
            start_i             = 1'b0;
            pool_result_valid_i = 1'b0;
        end
        for (int ch = 0; ch < int'(c); ch++) begin
            k = 0;
            while (!pool_last_o && k < 300) begin
                step();
                k++;
            end
            check("last_seen", 32'(pool_last_o), 32'd1);
            check("cur_ch", 32'(cur_ch_o), 32'(ch));
            check("wait_busy", 32'(busy_o), 32'd1);
            repeat (d) step();
            check("no_rd_wait", 32'(mem_rd_en_o), 32'd0);
            pool_result_valid_i = 1'b1;
            step();
            pool_result_valid_i = 1'b0;
            if (ch == int'(c) - 1) begin
                check("done", 32'(done_o), 32'd1);
                check("busy_fall", 32'(busy_o), 32'd0);
                check("cnt", cycle_cnt_o, exp_cnt);
            end else begin
                check("next_rd", 32'(mem_rd_en_o), 32'd1);
                check("next_addr", 32'(mem_addr_o), 32'(base + AW'(ch + 1)));
                check("next_ch", 32'(cur_ch_o), 32'(ch + 1));
            end
        end
        step();
        check("done_once", 32'(done_o), 32'd0);
        check("cnt_hold", cycle_cnt_o, exp_cnt);
        check("rd_q_empty", 32'(exp_addr.size()), 32'd0);
        check("dat_q_empty", 32'(exp_dat.size()), 32'd0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, 32'(busy_o), 32'd0);
        check({tag, "_done"}, 32'(done_o), 32'd0);
        check({tag, "_ch"}, 32'(cur_ch_o), 32'd0);
        check({tag, "_rd"}, 32'(mem_rd_en_o), 32'd0);
        check({tag, "_addr"}, 32'(mem_addr_o), 32'd0);
        check({tag, "_valid"}, 32'(pool_valid_o), 32'd0);
        check({tag, "_last"}, 32'(pool_last_o), 32'd0);
        check({tag, "_cnt"}, cycle_cnt_o, 32'd0);
        check({tag, "_data"}, 32'(pool_data_o), 32'(mem_rdata_i));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni              = 1'b0;
        start_i             = 1'b0;
        base_addr_i         = '0;
        num_ch_i            = '0;
        pool_result_valid_i = 1'b0;
        repeat (3) step();
        check_zero("rst");
        rst_ni = 1'b1;
        step();

        run_job(16'h0100, 16'd1, 2, 1'b0);
        run_job(16'h0000, 16'd4, 10, 1'b0);
        run_job(16'h0000, 16'd0, 0, 1'b0);
        run_job(16'hFFF0, 16'd2, 3, 1'b0);
        run_job(16'h0050, 16'd1, 4, 1'b1);

        // abort mid-burst after 20 reads, then restart from channel 0
        start_job(16'h0200, 16'd3);
        repeat (20) step();
        rst_ni = 1'b0;
        #1;
        check("rd_before_rst", 32'(exp_addr.size()), 32'(3 * PS - 20));
        check_zero("mid_rst");
        exp_addr.delete();
        exp_dat.delete();
        step();
        rst_ni = 1'b1;
        step();
        run_job(16'h0300, 16'd2, 3, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/avg_pool_feeder.md
# avg_pool_feeder

Channel-sequencing front end for the average-pooling stage. On a start command it reads a 7x7xC fp16 feature map, stored pixel-major (HWC), from the feature SRAM and re-streams it channel-major as 49-element bursts with a last flag. This matches the valid/last/data input of the pooling unit. It waits for the pooling result before starting the next channel, because the pooling unit only accepts a new burst once it is idle again.

## Interface
- DATA_WIDTH, 16, element width (fp16 bit pattern, never interpreted)
- ADDR_BITS, 16, SRAM address and channel-count width
- POOL_SIZE, 49, elements per channel burst (7x7)

- clk_i  in  1  clock, all logic on rising edge
- rst_ni  in  1  asynchronous, active-low reset
- start_i  in  1  start pulse; sampled only in IDLE
- base_addr_i  in  ADDR_BITS  address of pixel 0, channel 0; latched at start
- num_ch_i  in  ADDR_BITS  channel count C, also the pixel stride; latched at start
- busy_o  out  1  high in ISSUE or WAIT_RES
- done_o  out  1  one-cycle pulse when all channels are finished
- cur_ch_o  out  ADDR_BITS  channel currently being fed
- mem_rd_en_o  out  1  SRAM read strobe
- mem_addr_o  out  ADDR_BITS  SRAM read address
- mem_rdata_i  in  DATA_WIDTH  SRAM data, valid exactly one cycle after mem_rd_en_o
- pool_valid_o  out  1  element valid to the pooling unit
- pool_last_o  out  1  high with the 49th element of a channel
- pool_data_o  out  DATA_WIDTH  element, equal to mem_rdata_i
- pool_result_valid_i  in  1  pooling-unit result valid pulse
- cycle_cnt_o  out  32  see Configuration

## Operation
- States: IDLE, ISSUE, WAIT_RES, DONE.
- IDLE, start_i=1:
  - latch base_addr_i and num_ch_i
  - set ch=0, ptr=base, pix=0
  - go to ISSUE, or to DONE if num_ch_i==0
- ISSUE: each cycle assert mem_rd_en_o with mem_addr_o=ptr, then ptr+=C and pix+=1.
  - When pix==POOL_SIZE-1 is issued, go to WAIT_RES.
- Data path:
  - pool_valid_o is mem_rd_en_o delayed by 1 register.
  - pool_last_o is (rd_en && pix==POOL_SIZE-1) delayed by 1 register.
  - pool_data_o = mem_rdata_i.
- WAIT_RES, on pool_result_valid_i:
  - if ch==C-1, go to DONE
  - otherwise ch+=1, ptr=base+ch+1, pix=0, go to ISSUE
- DONE: done_o=1 for one cycle, then IDLE.
- Address arithmetic is modulo 2^ADDR_BITS; wrap is silent.
- Boundary rules:
  - start_i outside IDLE is ignored.
  - pool_result_valid_i outside WAIT_RES is ignored.
  - A result pulse coinciding with the last pool_valid_o is impossible by protocol; the block needs no special handling for it.
- Reset (any time, mid-burst included) forces IDLE. Every output goes to 0: busy_o, done_o, cur_ch_o, mem_rd_en_o, mem_addr_o, pool_valid_o, pool_last_o, cycle_cnt_o. pool_data_o follows mem_rdata_i.

## Timing
- Start sampled at cycle 0.
- mem_rd_en_o is high for cycles 1..49, addresses base+c, base+c+C, ..., base+c+48C.
- pool_valid_o is high for cycles 2..50; pool_last_o is high at cycle 50 only.
- busy_o rises at cycle 1.
- Result at cycle t leads to one of:
  - the next channel's first read at t+1
  - or, after the final channel, done_o at t+1 with busy_o low from t+1
- num_ch_i==0: done_o at cycle 1; no reads, busy_o never rises.
- Reads are back-to-back with no bubbles inside a burst. There is no downstream backpressure.

## Configuration
- AVG_POOL_FEEDER_CYCLE_CNT_EN defined:
  - cycle_cnt_o counts cycles with busy_o=1.
  - It clears on an accepted start and holds its value after done.
  - It saturates at 2^32-1.
- Not defined: cycle_cnt_o is tied to 0 and no counter is built.

## Test plan
- base=0x0100, C=1, start -> 49 reads at 0x0100..0x0130 stride 1, last on the 49th valid; a result pulse leads to done_o one cycle later.
- base=0x0000, C=4, results returned 10 cycles after each last -> four bursts. Channel 2 reads 0x0002, 0x0006, ..., 0x00C2; cur_ch_o steps 0..3; done_o fires once.
- C=0 start -> done_o at cycle 1, mem_rd_en_o never asserted, cycle_cnt_o=0.
- base=0xFFF0, C=2 -> the address wraps to 0x0000 after 0xFFFE with no error.
- start_i and a spurious pool_result_valid_i applied during ISSUE -> both ignored; the burst stays 49 reads.
- rst_ni low mid-burst (after read 20) -> all outputs 0 immediately. A new start after release re-runs channel 0 from pix 0.
